axil4_rr_arbiter: RTL and testbench

Two-master, one-slave AXI-Lite-4 arbiter that shares the single SRAM slave between the instruction cache (master 1) and the data cache (master 2). It has independent read and write arbiters, so one read and one write can be in flight at the same time. Each arbiter grants whole transactions round-robin: for a read, address then data; for a write, address and data then response. It sits between the two cache AXI master ports and the SRAM slave port, in place of a pass-through mux.

---
 rtl/axil4_rr_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_axil4_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil4_rr_arbiter.sv
// Two-master / one-slave AXI-Lite-4 arbiter with independent round-robin read and write arbiters.
// Define AXIL_ARB_FIXED_PRIO_EN to make the data cache (m2) win every tie instead.
module axil4_rr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   // master 1 (instruction cache)
   input  logic [ADDR_W-1:0] m1_readAddr_addr,
   input  logic              m1_readAddr_valid,
   output logic              m1_readAddr_ready,
   output logic [DATA_W-1:0] m1_readData_data,
   output logic              m1_readData_valid,
   input  logic              m1_readData_ready,
   input  logic [ADDR_W-1:0] m1_writeAddr_addr,
   input  logic              m1_writeAddr_valid,
   output logic              m1_writeAddr_ready,
   input  logic [DATA_W-1:0] m1_writeData_data,
   input  logic [STRB_W-1:0] m1_writeData_strb,
   input  logic              m1_writeData_valid,
   output logic              m1_writeData_ready,
   output logic [31:0]       m1_writeResp_msg,
   output logic              m1_writeResp_valid,
   input  logic              m1_writeResp_ready,
   // master 2 (data cache)
   input  logic [ADDR_W-1:0] m2_readAddr_addr,
   input  logic              m2_readAddr_valid,
   output logic              m2_readAddr_ready,
   output logic [DATA_W-1:0] m2_readData_data,
   output logic              m2_readData_valid,
   input  logic              m2_readData_ready,
   input  logic [ADDR_W-1:0] m2_writeAddr_addr,
   input  logic              m2_writeAddr_valid,
   output logic              m2_writeAddr_ready,
   input  logic [DATA_W-1:0] m2_writeData_data,
   input  logic [STRB_W-1:0] m2_writeData_strb,
   input  logic              m2_writeData_valid,
   output logic              m2_writeData_ready,
   output logic [31:0]       m2_writeResp_msg,
   output logic              m2_writeResp_valid,
   input  logic              m2_writeResp_ready,
   // slave (SRAM)
   output logic [ADDR_W-1:0] s_readAddr_addr,
   output logic              s_readAddr_valid,
   input  logic              s_readAddr_ready,
   input  logic [DATA_W-1:0] s_readData_data,
   input  logic              s_readData_valid,
   output logic              s_readData_ready,
   output logic [ADDR_W-1:0] s_writeAddr_addr,
   output logic              s_writeAddr_valid,
   input  logic              s_writeAddr_ready,
   output logic [DATA_W-1:0] s_writeData_data,
   output logic [STRB_W-1:0] s_writeData_strb,
   output logic              s_writeData_valid,
   input  logic              s_writeData_ready,
   input  logic [31:0]       s_writeResp_msg,
   input  logic              s_writeResp_valid,
   output logic              s_writeResp_ready,
   // ownership and FSM observation
   output logic [1:0]        rd_grant,
   output logic [1:0]        wr_grant,
   output logic [1:0]        rdState,
   output logic [1:0]        wrState
);

   // Handshake rule on every channel: a beat transfers on a rising edge where valid & ready;
   // valid never waits on ready, and the owner must hold valid until its beat transfers.
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rdState_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wrState_t;

   rdState_t   rdCur, rdNext;
   wrState_t   wrCur, wrNext;
   logic [1:0] rdGrantNext, wrGrantNext;
   logic [1:0] rdWin, wrWin;
   logic       awDone, wDone;
   logic       awHs, wHs, rdDataHs, wrRespHs;

   assign awHs     = s_writeAddr_valid & s_writeAddr_ready;
   assign wHs      = s_writeData_valid & s_writeData_ready;
   assign rdDataHs = (rdCur == R_DATA) & s_readData_valid & s_readData_ready;
   assign wrRespHs = (wrCur == W_RESP) & s_writeResp_valid & s_writeResp_ready;
   assign rdState  = rdCur;
   assign wrState  = wrCur;

`ifdef AXIL_ARB_FIXED_PRIO_EN
   assign rdWin = m2_readAddr_valid  ? 2'b10 : {1'b0, m1_readAddr_valid};
   assign wrWin = m2_writeAddr_valid ? 2'b10 : {1'b0, m1_writeAddr_valid};
`else
   // Last-owner pointers: 1 means m2 won the previous grant, so m1 takes the next tie.
   logic rdLastM2, wrLastM2;

   assign rdWin = (m1_readAddr_valid & m2_readAddr_valid)
                  ? (rdLastM2 ? 2'b01 : 2'b10) : {m2_readAddr_valid, m1_readAddr_valid};
   assign wrWin = (m1_writeAddr_valid & m2_writeAddr_valid)
                  ? (wrLastM2 ? 2'b01 : 2'b10) : {m2_writeAddr_valid, m1_writeAddr_valid};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdLastM2 <= 1'b1;
         wrLastM2 <= 1'b1;
      end else begin
         if (rdDataHs) rdLastM2 <= rd_grant[1];
         if (wrRespHs) wrLastM2 <= wr_grant[1];
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdCur    <= R_IDLE;
         wrCur    <= W_IDLE;
         rd_grant <= 2'b00;
         wr_grant <= 2'b00;
         awDone   <= 1'b0;
         wDone    <= 1'b0;
      end else begin
         rdCur    <= rdNext;
         wrCur    <= wrNext;
         rd_grant <= rdGrantNext;
         wr_grant <= wrGrantNext;
         if (wrCur == W_REQ) begin
            if (awHs) awDone <= 1'b1;
            if (wHs)  wDone  <= 1'b1;
         end else if (wrRespHs) begin
            awDone <= 1'b0;
            wDone  <= 1'b0;
         end
      end
   end

   always_comb begin
      rdNext            = rdCur;
      rdGrantNext       = rd_grant;
      s_readAddr_addr   = '0;
      s_readAddr_valid  = 1'b0;
      s_readData_ready  = 1'b0;
      m1_readAddr_ready = 1'b0;
      m2_readAddr_ready = 1'b0;
      m1_readData_data  = '0;
      m1_readData_valid = 1'b0;
      m2_readData_data  = '0;
      m2_readData_valid = 1'b0;
      case (rdCur)
         R_IDLE: if (rdWin != 2'b00) begin
            rdGrantNext = rdWin;
            rdNext      = R_ADDR;
         end
         R_ADDR: begin
            s_readAddr_addr   = rd_grant[0] ? m1_readAddr_addr  : m2_readAddr_addr;
            s_readAddr_valid  = rd_grant[0] ? m1_readAddr_valid : m2_readAddr_valid;
            m1_readAddr_ready = rd_grant[0] & s_readAddr_ready;
            m2_readAddr_ready = rd_grant[1] & s_readAddr_ready;
            if (s_readAddr_valid & s_readAddr_ready) rdNext = R_DATA;
         end
         R_DATA: begin
            m1_readData_data  = rd_grant[0] ? s_readData_data : '0;
            m2_readData_data  = rd_grant[1] ? s_readData_data : '0;
            m1_readData_valid = rd_grant[0] & s_readData_valid;
            m2_readData_valid = rd_grant[1] & s_readData_valid;
            s_readData_ready  = rd_grant[0] ? m1_readData_ready : m2_readData_ready;
            if (s_readData_valid & s_readData_ready) begin
               rdNext      = R_IDLE;
               rdGrantNext = 2'b00;
            end
         end
         default: begin
            rdNext      = R_IDLE;
            rdGrantNext = 2'b00;
         end
      endcase
   end

   always_comb begin
      wrNext             = wrCur;
      wrGrantNext        = wr_grant;
      s_writeAddr_addr   = '0;
      s_writeAddr_valid  = 1'b0;
      s_writeData_data   = '0;
      s_writeData_strb   = '0;
      s_writeData_valid  = 1'b0;
      s_writeResp_ready  = 1'b0;
      m1_writeAddr_ready = 1'b0;
      m2_writeAddr_ready = 1'b0;
      m1_writeData_ready = 1'b0;
      m2_writeData_ready = 1'b0;
      m1_writeResp_msg   = '0;
      m1_writeResp_valid = 1'b0;
      m2_writeResp_msg   = '0;
      m2_writeResp_valid = 1'b0;
      case (wrCur)
         W_IDLE: if (wrWin != 2'b00) begin
            wrGrantNext = wrWin;
            wrNext      = W_REQ;
         end
         W_REQ: begin
            // A channel that already transferred stays quiet until the response completes.
            s_writeAddr_addr   = wr_grant[0] ? m1_writeAddr_addr : m2_writeAddr_addr;
            s_writeAddr_valid  = (wr_grant[0] ? m1_writeAddr_valid : m2_writeAddr_valid) & ~awDone;
            s_writeData_data   = wr_grant[0] ? m1_writeData_data : m2_writeData_data;
            s_writeData_strb   = wr_grant[0] ? m1_writeData_strb : m2_writeData_strb;
            s_writeData_valid  = (wr_grant[0] ? m1_writeData_valid : m2_writeData_valid) & ~wDone;
            m1_writeAddr_ready = wr_grant[0] & s_writeAddr_ready & ~awDone;
            m2_writeAddr_ready = wr_grant[1] & s_writeAddr_ready & ~awDone;
            m1_writeData_ready = wr_grant[0] & s_writeData_ready & ~wDone;
            m2_writeData_ready = wr_grant[1] & s_writeData_ready & ~wDone;
            if ((awDone | (s_writeAddr_valid & s_writeAddr_ready)) &
                (wDone  | (s_writeData_valid & s_writeData_ready)))
               wrNext = W_RESP;
         end
         W_RESP: begin
            m1_writeResp_msg   = wr_grant[0] ? s_writeResp_msg : '0;
            m2_writeResp_msg   = wr_grant[1] ? s_writeResp_msg : '0;
            m1_writeResp_valid = wr_grant[0] & s_writeResp_valid;
            m2_writeResp_valid = wr_grant[1] & s_writeResp_valid;
            s_writeResp_ready  = wr_grant[0] ? m1_writeResp_ready : m2_writeResp_ready;
            if (s_writeResp_valid & s_writeResp_ready) begin
               wrNext      = W_IDLE;
               wrGrantNext = 2'b00;
            end
         end
         default: begin
            wrNext      = W_IDLE;
            wrGrantNext = 2'b00;
         end
      endcase
   end

endmodule

// File: tb/tb_axil4_rr_arbiter.sv
// Directed bench for axil4_rr_arbiter: reads, contention order, write ordering, concurrency, reset abort.
module tb_axil4_rr_arbiter;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int SW = DW / 8;
`ifdef AXIL_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam logic [DW-1:0] PAT = 128'h0F0E0D0C0B0A09080706050403020100;

   logic clk, rst;
   logic [AW-1:0] m1_readAddr_addr, m2_readAddr_addr, m1_writeAddr_addr, m2_writeAddr_addr;
   logic m1_readAddr_valid, m1_readAddr_ready, m2_readAddr_valid, m2_readAddr_ready;
   logic [DW-1:0] m1_readData_data, m2_readData_data, m1_writeData_data, m2_writeData_data;
   logic m1_readData_valid, m1_readData_ready, m2_readData_valid, m2_readData_ready;
   logic m1_writeAddr_valid, m1_writeAddr_ready, m2_writeAddr_valid, m2_writeAddr_ready;
   logic [SW-1:0] m1_writeData_strb, m2_writeData_strb, s_writeData_strb;
   logic m1_writeData_valid, m1_writeData_ready, m2_writeData_valid, m2_writeData_ready;
   logic [31:0] m1_writeResp_msg, m2_writeResp_msg, s_writeResp_msg;
   logic m1_writeResp_valid, m1_writeResp_ready, m2_writeResp_valid, m2_writeResp_ready;
   logic [AW-1:0] s_readAddr_addr, s_writeAddr_addr;
   logic s_readAddr_valid, s_readAddr_ready, s_readData_valid, s_readData_ready;
   logic [DW-1:0] s_readData_data, s_writeData_data;
   logic s_writeAddr_valid, s_writeAddr_ready, s_writeData_valid, s_writeData_ready;
   logic s_writeResp_valid, s_writeResp_ready;
   logic [1:0] rd_grant, wr_grant, rdState, wrState;

   int nAssert = 0;
   int nFail = 0;
   logic [AW-1:0] expQ[$];
   logic [1:0] firstGrant, secondGrant, expGrant;

   axil4_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
      .clk(clk), .rst(rst),
      .m1_readAddr_addr(m1_readAddr_addr), .m1_readAddr_valid(m1_readAddr_valid),
      .m1_readAddr_ready(m1_readAddr_ready), .m1_readData_data(m1_readData_data),
      .m1_readData_valid(m1_readData_valid), .m1_readData_ready(m1_readData_ready),
      .m1_writeAddr_addr(m1_writeAddr_addr), .m1_writeAddr_valid(m1_writeAddr_valid),
      .m1_writeAddr_ready(m1_writeAddr_ready), .m1_writeData_data(m1_writeData_data),
      .m1_writeData_strb(m1_writeData_strb), .m1_writeData_valid(m1_writeData_valid),
      .m1_writeData_ready(m1_writeData_ready), .m1_writeResp_msg(m1_writeResp_msg),
      .m1_writeResp_valid(m1_writeResp_valid), .m1_writeResp_ready(m1_writeResp_ready),
      .m2_readAddr_addr(m2_readAddr_addr), .m2_readAddr_valid(m2_readAddr_valid),
      .m2_readAddr_ready(m2_readAddr_ready), .m2_readData_data(m2_readData_data),
      .m2_readData_valid(m2_readData_valid), .m2_readData_ready(m2_readData_ready),
      .m2_writeAddr_addr(m2_writeAddr_addr), .m2_writeAddr_valid(m2_writeAddr_valid),
      .m2_writeAddr_ready(m2_writeAddr_ready), .m2_writeData_data(m2_writeData_data),
      .m2_writeData_strb(m2_writeData_strb), .m2_writeData_valid(m2_writeData_valid),
      .m2_writeData_ready(m2_writeData_ready), .m2_writeResp_msg(m2_writeResp_msg),
      .m2_writeResp_valid(m2_writeResp_valid), .m2_writeResp_ready(m2_writeResp_ready),
      .s_readAddr_addr(s_readAddr_addr), .s_readAddr_valid(s_readAddr_valid),
      .s_readAddr_ready(s_readAddr_ready), .s_readData_data(s_readData_data),
      .s_readData_valid(s_readData_valid), .s_readData_ready(s_readData_ready),
      .s_writeAddr_addr(s_writeAddr_addr), .s_writeAddr_valid(s_writeAddr_valid),
      .s_writeAddr_ready(s_writeAddr_ready), .s_writeData_data(s_writeData_data),
      .s_writeData_strb(s_writeData_strb), .s_writeData_valid(s_writeData_valid),
      .s_writeData_ready(s_writeData_ready), .s_writeResp_msg(s_writeResp_msg),
      .s_writeResp_valid(s_writeResp_valid), .s_writeResp_ready(s_writeResp_ready),
      .rd_grant(rd_grant), .wr_grant(wr_grant), .rdState(rdState), .wrState(wrState)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      nAssert++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      m1_readAddr_addr = '0;  m1_readAddr_valid = 0;  m1_readData_ready = 0;
      m2_readAddr_addr = '0;  m2_readAddr_valid = 0;  m2_readData_ready = 0;
      m1_writeAddr_addr = '0; m1_writeAddr_valid = 0; m1_writeData_data = '0;
      m1_writeData_strb = '0; m1_writeData_valid = 0; m1_writeResp_ready = 0;
      m2_writeAddr_addr = '0; m2_writeAddr_valid = 0; m2_writeData_data = '0;
      m2_writeData_strb = '0; m2_writeData_valid = 0; m2_writeResp_ready = 0;
      s_readAddr_ready = 0;   s_readData_data = '0;   s_readData_valid = 0;
      s_writeAddr_ready = 0;  s_writeData_ready = 0;
      s_writeResp_msg = '0;   s_writeResp_valid = 0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      clearInputs();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clearInputs();
      #12;
      // reset state
      check("rstRdGrant", rd_grant, 2'b00);
      check("rstWrGrant", wr_grant, 2'b00);
      check("rstRdState", rdState, 2'd0);
      check("rstWrState", wrState, 2'd0);
      check("rstSReadValid", s_readAddr_valid, 1'b0);
      check("rstSWriteValid", s_writeAddr_valid, 1'b0);
      doReset();

      // single read by m1
      m1_readAddr_addr = 32'h0; m1_readAddr_valid = 1; #1;
      check("rd1IdleQuiet", s_readAddr_valid, 1'b0);
      tick();
      check("rd1Grant", rd_grant, 2'b01);
      check("rd1SValid", s_readAddr_valid, 1'b1);
      check("rd1SAddr", s_readAddr_addr, 32'h0);
      s_readAddr_ready = 1; #1;
      check("rd1M1Ready", m1_readAddr_ready, 1'b1);
      check("rd1M2Ready", m2_readAddr_ready, 1'b0);
      tick();
      m1_readAddr_valid = 0; s_readAddr_ready = 0; #1;
      check("rd1StateData", rdState, 2'd2);
      for (int i = 0; i < 2; i++) begin
         check("rd1NoDataYet", m1_readData_valid, 1'b0);
         tick();
      end
      s_readData_data = PAT; s_readData_valid = 1; m1_readData_ready = 1; #1;
      check("rd1M1Data", m1_readData_data, PAT);
      check("rd1M1Valid", m1_readData_valid, 1'b1);
      check("rd1M2Valid", m2_readData_valid, 1'b0);
      check("rd1M2Data", m2_readData_data, '0);
      check("rd1SReady", s_readData_ready, 1'b1);
      tick();
      s_readData_valid = 0; m1_readData_ready = 0; #1;
      check("rd1GrantIdle", rd_grant, 2'b00);

      // simultaneous reads from reset
      doReset();
      firstGrant  = FIXED ? 2'b10 : 2'b01;
      secondGrant = ~firstGrant;
      expQ.push_back(FIXED ? 32'h20 : 32'h10);
      expQ.push_back(FIXED ? 32'h10 : 32'h20);
      m1_readAddr_addr = 32'h10; m2_readAddr_addr = 32'h20;
      m1_readAddr_valid = 1; m2_readAddr_valid = 1;
      tick();
      check("simFirstGrant", rd_grant, firstGrant);
      check("simFirstAddr", s_readAddr_addr, expQ.pop_front());
      s_readAddr_ready = 1;
      tick();
      if (firstGrant[0]) m1_readAddr_valid = 0; else m2_readAddr_valid = 0;
      s_readAddr_ready = 0;
      s_readData_valid = 1; s_readData_data = PAT; m1_readData_ready = 1; m2_readData_ready = 1;
      tick();
      s_readData_valid = 0; #1;
      check("simGapIdle", rd_grant, 2'b00);
      tick();
      check("simSecondGrant", rd_grant, secondGrant);
      check("simSecondAddr", s_readAddr_addr, expQ.pop_front());
      check("simSecondValid", s_readAddr_valid, 1'b1);
      s_readAddr_ready = 1;
      tick();
      m1_readAddr_valid = 0; m2_readAddr_valid = 0; s_readAddr_ready = 0; s_readData_valid = 1;
      tick();
      s_readData_valid = 0; #1;
      check("simDoneIdle", rd_grant, 2'b00);
      check("simQueueEmpty", expQ.size(), 0);

      // back-to-back contention
      clearInputs();
      m1_readAddr_valid = 1; m2_readAddr_valid = 1;
      m1_readData_ready = 1; m2_readData_ready = 1;
      s_readAddr_ready = 1; s_readData_valid = 1;
      for (int i = 0; i < 4; i++) begin
         expGrant = FIXED ? 2'b10 : ((i % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         check($sformatf("b2bGrant%0d", i), rd_grant, expGrant);
         tick();
         tick();
      end
      clearInputs(); #1;

      // write: data accepted two cycles before address
      m2_writeAddr_addr = 32'h40; m2_writeAddr_valid = 1;
      m2_writeData_data = PAT; m2_writeData_strb = 16'hFFFF; m2_writeData_valid = 1;
      s_writeData_ready = 1;
      tick();
      check("wrGrant", wr_grant, 2'b10);
      check("wrSDataValid", s_writeData_valid, 1'b1);
      check("wrSStrb", s_writeData_strb, 16'hFFFF);
      check("wrSAddr", s_writeAddr_addr, 32'h40);
      check("wrM2DataReady", m2_writeData_ready, 1'b1);
      check("wrM1DataReady", m1_writeData_ready, 1'b0);
      tick();
      m2_writeData_valid = 0; #1;
      check("wrDataQuiet", s_writeData_valid, 1'b0);
      check("wrAddrStillValid", s_writeAddr_valid, 1'b1);
      tick();
      check("wrStillReq", wrState, 2'd1);
      s_writeAddr_ready = 1; #1;
      check("wrM2AddrReady", m2_writeAddr_ready, 1'b1);
      tick();
      m2_writeAddr_valid = 0; s_writeAddr_ready = 0; s_writeData_ready = 0; #1;
      check("wrStateResp", wrState, 2'd2);
      check("wrNoRespYet", m2_writeResp_valid, 1'b0);
      s_writeResp_msg = 32'h0; s_writeResp_valid = 1; m2_writeResp_ready = 1; #1;
      check("wrM2RespValid", m2_writeResp_valid, 1'b1);
      check("wrM2RespMsg", m2_writeResp_msg, 32'h0);
      check("wrM1RespValid", m1_writeResp_valid, 1'b0);
      check("wrSRespReady", s_writeResp_ready, 1'b1);
      tick();
      s_writeResp_valid = 0; m2_writeResp_ready = 0; #1;
      check("wrGrantIdle", wr_grant, 2'b00);

      // concurrent m1 read and m2 write
      clearInputs();
      m1_readAddr_addr = 32'h0; m1_readAddr_valid = 1;
      m2_writeAddr_addr = 32'h40; m2_writeAddr_valid = 1;
      m2_writeData_data = PAT; m2_writeData_strb = 16'hFFFF; m2_writeData_valid = 1;
      tick();
      check("ccRdGrant", rd_grant, 2'b01);
      check("ccWrGrant", wr_grant, 2'b10);
      check("ccSReadValid", s_readAddr_valid, 1'b1);
      check("ccSWriteValid", s_writeAddr_valid, 1'b1);
      check("ccSDataValid", s_writeData_valid, 1'b1);
      s_readAddr_ready = 1; s_writeAddr_ready = 1; s_writeData_ready = 1;
      tick();
      m1_readAddr_valid = 0; m2_writeAddr_valid = 0; m2_writeData_valid = 0;
      s_readAddr_ready = 0; s_writeAddr_ready = 0; s_writeData_ready = 0;
      s_readData_valid = 1; s_readData_data = PAT; m1_readData_ready = 1;
      s_writeResp_valid = 1; s_writeResp_msg = 32'h5; m2_writeResp_ready = 1; #1;
      check("ccRdData", m1_readData_data, PAT);
      check("ccWrMsg", m2_writeResp_msg, 32'h5);
      tick();
      clearInputs(); #1;
      check("ccRdIdle", rd_grant, 2'b00);
      check("ccWrIdle", wr_grant, 2'b00);

      // reset during R_DATA
      m1_readAddr_addr = 32'h80; m1_readAddr_valid = 1; s_readAddr_ready = 1;
      tick();
      tick();
      m1_readAddr_valid = 0; s_readAddr_ready = 0;
      s_readData_valid = 1; s_readData_data = PAT; #1;
      check("rstMidValidBefore", m1_readData_valid, 1'b1);
      rst = 1'b1; #1;
      check("rstMidValid", m1_readData_valid, 1'b0);
      check("rstMidData", m1_readData_data, '0);
      check("rstMidGrant", rd_grant, 2'b00);
      check("rstMidSReady", s_readData_ready, 1'b0);
      check("rstMidState", rdState, 2'd0);
      #2;
      rst = 1'b0;
      clearInputs();
      m2_readAddr_addr = 32'h30; m2_readAddr_valid = 1;
      tick();
      check("postRstGrant", rd_grant, 2'b10);
      check("postRstAddr", s_readAddr_addr, 32'h30);
      s_readAddr_ready = 1;
      tick();
      m2_readAddr_valid = 0; s_readAddr_ready = 0;
      s_readData_valid = 1; m2_readData_ready = 1;
      tick();
      clearInputs(); #1;
      check("postRstIdle", rd_grant, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
